// File: rtl/tc_timer_bank.sv
// Prescaled global timebase plus CHANNELS down-counting one-shot/periodic timers
// with a small register port for programming and readback.
//
// channel state | meaning
// IDLE          | run=0, COUNT holds its value
// RUNNING       | run=1, COUNT decrements on each tick and reloads or stops at expiry
module tc_timer_bank #(
   parameter int               WIDTH      = 64,
   parameter int               CHANNELS   = 4,
   parameter int               PRESCALE_W = 8,
   parameter logic [WIDTH-1:0] START_TIME = '0,
   parameter int               CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic [WIDTH-1:0]      time_out,
   input  logic                  wr_en,
   input  logic [CH_W-1:0]       wr_ch,
   input  logic [1:0]            wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic [CH_W-1:0]       rd_ch,
   input  logic [1:0]            rd_addr,
   output logic [WIDTH-1:0]      rd_data,
   output logic [CHANNELS-1:0]   expire,
   output logic [CHANNELS-1:0]   irq
);

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_RELOAD = 2'd1;
   localparam logic [1:0] A_COUNT  = 2'd2;
   localparam logic [1:0] A_STATUS = 2'd3;

   logic [PRESCALE_W-1:0] pre_q, pre_d;
   logic [WIDTH-1:0]      tbase_q, tbase_d;
   logic                  tick;

   logic [CHANNELS-1:0]   run_q, run_d;
   logic [CHANNELS-1:0]   per_q, per_d;
   logic [CHANNELS-1:0]   irq_q, irq_d;
   logic [CHANNELS-1:0]   exp_q, exp_d;
   logic [WIDTH-1:0]      reload_q [CHANNELS];
   logic [WIDTH-1:0]      reload_d [CHANNELS];
   logic [WIDTH-1:0]      count_q  [CHANNELS];
   logic [WIDTH-1:0]      count_d  [CHANNELS];
   logic [CHANNELS-1:0]   wr_sel;
   logic [WIDTH-1:0]      rd_q, rd_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q   <= '0;
         tbase_q <= START_TIME;
         run_q   <= '0;
         per_q   <= '0;
         irq_q   <= '0;
         exp_q   <= '0;
         rd_q    <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            reload_q[c] <= '0;
            count_q[c]  <= '0;
         end
      end else begin
         pre_q    <= pre_d;
         tbase_q  <= tbase_d;
         run_q    <= run_d;
         per_q    <= per_d;
         irq_q    <= irq_d;
         exp_q    <= exp_d;
         rd_q     <= rd_d;
         reload_q <= reload_d;
         count_q  <= count_d;
      end
   end

   // Using >= lets a reduced prescale take effect on the very next enabled cycle.
   always_comb begin
      tick    = en && (pre_q >= prescale);
      pre_d   = pre_q;
      if (en) pre_d = tick ? '0 : pre_q + PRESCALE_W'(1);
      tbase_d = tick ? tbase_q + WIDTH'(1) : tbase_q;
   end

   always_comb begin
      wr_sel = '0;
      for (int c = 0; c < CHANNELS; c++)
         wr_sel[c] = wr_en && (wr_ch == CH_W'(c));
   end

   always_comb begin
      run_d    = run_q;
      per_d    = per_q;
      irq_d    = irq_q;
      exp_d    = '0;
      reload_d = reload_q;
      count_d  = count_q;
      for (int c = 0; c < CHANNELS; c++) begin
         // A register write drops this channel's tick; an irq clear does not.
         if (tick && run_q[c] && !(wr_sel[c] && wr_addr != A_STATUS)) begin
            if (count_q[c] <= WIDTH'(1)) begin
               exp_d[c] = 1'b1;
               irq_d[c] = 1'b1;
               if (per_q[c]) begin
                  count_d[c] = reload_q[c];
               end else begin
                  count_d[c] = '0;
                  run_d[c]   = 1'b0;
               end
            end else begin
               count_d[c] = count_q[c] - WIDTH'(1);
            end
         end
         if (wr_sel[c]) begin
            case (wr_addr)
               A_CTRL: begin
                  run_d[c] = wr_data[0];
                  per_d[c] = wr_data[1];
                  if (!run_q[c] && wr_data[0]) count_d[c] = reload_q[c];
               end
               A_RELOAD: reload_d[c] = wr_data;
               A_COUNT:  count_d[c]  = wr_data;
               default:  if (wr_data[0] && !exp_d[c]) irq_d[c] = 1'b0;
            endcase
         end
      end
   end

   always_comb begin
      rd_d = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (rd_ch == CH_W'(c)) begin
            case (rd_addr)
               A_CTRL:   rd_d = WIDTH'({per_q[c], run_q[c]});
               A_RELOAD: rd_d = reload_q[c];
               A_COUNT:  rd_d = count_q[c];
               default:  rd_d = WIDTH'(irq_q[c]);
            endcase
         end
      end
   end

   always_comb begin
      time_out = tbase_q;
      rd_data  = rd_q;
      expire   = exp_q;
      irq      = irq_q;
   end

endmodule

// File: tb/tb_tc_timer_bank.sv
// Directed bench for tc_timer_bank: stimulus queues expected values with a due cycle,
// a negedge monitor compares them against the DUT outputs.
module tb_tc_timer_bank;

   localparam int W   = 16;
   localparam int NCH = 5;
   localparam int PW  = 8;
   localparam int CW  = 3;

   localparam int K_RD    = 0;
   localparam int K_TIME  = 1;
   localparam int K_IRQ   = 2;
   localparam int K_EXP   = 3;
   localparam int K_CNT   = 4;
   localparam int K_TIME2 = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en  = 1'b0;
   logic [PW-1:0] prescale = '0;
   logic [W-1:0]  time_out;
   logic          wr_en = 1'b0;
   logic [CW-1:0] wr_ch = '0;
   logic [1:0]    wr_addr = '0;
   logic [W-1:0]  wr_data = '0;
   logic [CW-1:0] rd_ch = '0;
   logic [1:0]    rd_addr = '0;
   logic [W-1:0]  rd_data;
   logic [NCH-1:0] expire;
   logic [NCH-1:0] irq;

   logic          en2 = 1'b0;
   logic [7:0]    time2;
   logic [7:0]    rd_data2;
   logic [0:0]    expire2;
   logic [0:0]    irq2;

   tc_timer_bank #(.WIDTH(W), .CHANNELS(NCH), .PRESCALE_W(PW), .START_TIME(16'd100)) dut (
      .clk(clk), .rst(rst), .en(en), .prescale(prescale), .time_out(time_out),
      .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data),
      .expire(expire), .irq(irq)
   );

   tc_timer_bank #(.WIDTH(8), .CHANNELS(1), .PRESCALE_W(PW), .START_TIME(8'd254)) dut_wrap (
      .clk(clk), .rst(rst), .en(en2), .prescale(8'd0), .time_out(time2),
      .wr_en(1'b0), .wr_ch(1'b0), .wr_addr(2'd0), .wr_data(8'd0),
      .rd_ch(1'b0), .rd_addr(2'd0), .rd_data(rd_data2),
      .expire(expire2), .irq(irq2)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      int          due;
      int          kind;
      int          ch;
      logic [W-1:0] exp;
      string       name;
   } chk_t;

   chk_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   exp_log [NCH];

   initial for (int c = 0; c < NCH; c++) exp_log[c] = 0;

   logic [W-1:0] act;

   always @(negedge clk) begin : monitor
      int i;
      for (int c = 0; c < NCH; c++)
         if (expire[c] === 1'b1) exp_log[c]++;
      i = 0;
      while (i < sb.size()) begin
         if (sb[i].due == cyc) begin
            case (sb[i].kind)
               K_RD:    act = rd_data;
               K_TIME:  act = time_out;
               K_IRQ:   act = W'(irq);
               K_EXP:   act = W'(expire);
               K_CNT:   act = W'(exp_log[sb[i].ch]);
               default: act = W'(time2);
            endcase
            n_vec++;
            if (act !== sb[i].exp) begin
               n_bad++;
               $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                        sb[i].name, act, sb[i].exp, cyc);
            end
            sb.delete(i);
         end else begin
            i++;
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input int dly, input int kind, input int ch, input logic [W-1:0] e,
                       input string nm);
      chk_t c;
      c.due  = cyc + dly;
      c.kind = kind;
      c.ch   = ch;
      c.exp  = e;
      c.name = nm;
      sb.push_back(c);
   endtask

   task automatic expect_now(input int kind, input logic [W-1:0] e, input string nm);
      push(0, kind, 0, e, nm);
   endtask

   task automatic wr(input int ch, input int addr, input logic [W-1:0] d);
      wr_en   = 1'b1;
      wr_ch   = CW'(ch);
      wr_addr = 2'(addr);
      wr_data = d;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic rd(input int ch, input int addr, input logic [W-1:0] e, input string nm);
      rd_ch   = CW'(ch);
      rd_addr = 2'(addr);
      push(1, K_RD, 0, e, nm);
      step();
   endtask

   initial begin
      // reset values
      step(2);
      expect_now(K_TIME, 16'd100, "rst_time");
      expect_now(K_IRQ, 16'd0, "rst_irq");
      expect_now(K_EXP, 16'd0, "rst_expire");
      expect_now(K_RD, 16'd0, "rst_rd_data");
      step();
      rst = 1'b0;

      // timebase, prescale 0
      en = 1'b1;
      prescale = 8'd0;
      step(5);
      en = 1'b0;
      expect_now(K_TIME, 16'd105, "tb_prescale0");
      n_vec++;
      if (time_out !== 16'd105) begin
         n_bad++;
         $display("FAIL tb_prescale0_direct: got 0x%0h", time_out);
      end

      // prescale 3: 12 enabled cycles give 3 ticks, then freeze with en low
      prescale = 8'd3;
      en = 1'b1;
      step(12);
      en = 1'b0;
      expect_now(K_TIME, 16'd108, "tb_prescale3");
      n_vec++;
      if (time_out !== 16'd108) begin
         n_bad++;
         $display("FAIL tb_prescale3_direct: got 0x%0h", time_out);
      end
      step(4);
      expect_now(K_TIME, 16'd108, "tb_en_low_hold");
      n_vec++;
      if (time_out !== 16'd108) begin
         n_bad++;
         $display("FAIL tb_en_low_hold_direct: got 0x%0h", time_out);
      end

      // lowering prescale below pre_cnt ticks on the next enabled cycle
      en = 1'b1;
      step(2);
      prescale = 8'd0;
      step();
      en = 1'b0;
      expect_now(K_TIME, 16'd109, "tb_prescale_lowered");
      n_vec++;
      if (time_out !== 16'd109) begin
         n_bad++;
         $display("FAIL tb_prescale_lowered_direct: got 0x%0h", time_out);
      end

      // ch1 one-shot, reload 4
      wr(1, 1, 16'd4);
      wr(1, 0, 16'd1);
      en = 1'b1;
      step(3);
      expect_now(K_EXP, 16'h00, "os_no_early_expire");
      step();
      expect_now(K_EXP, 16'h02, "os_expire");
      expect_now(K_IRQ, 16'h02, "os_irq");
      step();
      expect_now(K_EXP, 16'h00, "os_pulse_one_cycle");
      en = 1'b0;
      rd(1, 0, 16'd0, "os_ctrl_cleared");
      rd(1, 2, 16'd0, "os_count_zero");
      rd(1, 3, 16'd1, "os_status");

      // ch0 periodic, reload 2, with irq clear colliding with an expiry
      wr(0, 1, 16'd2);
      wr(0, 0, 16'd3);
      en = 1'b1;
      step();
      expect_now(K_EXP, 16'h00, "per_t1");
      step();
      expect_now(K_EXP, 16'h01, "per_exp1");
      expect_now(K_IRQ, 16'h03, "per_irq1");
      step();
      expect_now(K_EXP, 16'h00, "per_gap");
      wr_en = 1'b1;
      wr_ch = 3'd0;
      wr_addr = 2'd3;
      wr_data = 16'd1;
      step();
      expect_now(K_EXP, 16'h01, "per_exp2");
      expect_now(K_IRQ, 16'h03, "irq_set_wins");
      step();
      wr_en = 1'b0;
      expect_now(K_IRQ, 16'h02, "irq_clear");
      step(5);
      en = 1'b0;
      push(1, K_CNT, 0, 16'd5, "per_pulse_count");
      step();
      rd(0, 2, 16'd2, "per_reloaded_count");
      rd(0, 0, 16'd3, "per_ctrl_running");

      // reload 0 behaves as 1
      wr(0, 0, 16'd0);
      wr(4, 1, 16'd0);
      wr(4, 0, 16'd1);
      en = 1'b1;
      step();
      en = 1'b0;
      expect_now(K_EXP, 16'h10, "reload0_expire");
      expect_now(K_IRQ, 16'h13, "reload0_irq");

      // COUNT write beats a same-cycle tick
      wr(3, 1, 16'd10);
      wr(3, 0, 16'd1);
      en = 1'b1;
      wr_en = 1'b1;
      wr_ch = 3'd3;
      wr_addr = 2'd2;
      wr_data = 16'd5;
      step();
      wr_en = 1'b0;
      step();
      en = 1'b0;
      rd(3, 2, 16'd4, "wr_beats_tick");

      // reset mid-operation
      wr(2, 1, 16'd7);
      wr(2, 0, 16'd1);
      rd(2, 2, 16'd7, "pre_rst_count");
      @(negedge clk);
      #1;
      rst = 1'b1;
      push(1, K_TIME, 0, 16'd100, "mid_rst_time");
      push(1, K_IRQ, 0, 16'd0, "mid_rst_irq");
      push(1, K_EXP, 0, 16'd0, "mid_rst_expire");
      push(1, K_RD, 0, 16'd0, "mid_rst_rd_data");
      step(2);
      rst = 1'b0;
      rd(2, 2, 16'd0, "post_rst_count");
      rd(2, 0, 16'd0, "post_rst_ctrl");
      en = 1'b1;
      step(8);
      en = 1'b0;
      push(0, K_CNT, 2, 16'd0, "post_rst_ch2_idle");
      push(0, K_CNT, 3, 16'd0, "post_rst_ch3_idle");
      step();

      // out-of-range channel writes and reads
      wr(5, 2, 16'h0055);
      wr(5, 1, 16'h0077);
      wr(5, 0, 16'd1);
      wr(7, 2, 16'h0099);
      rd(5, 2, 16'd0, "oor_rd5_count");
      rd(5, 1, 16'd0, "oor_rd5_reload");
      rd(1, 2, 16'd0, "oor_alias1_count");
      rd(1, 1, 16'd0, "oor_alias1_reload");
      rd(1, 0, 16'd0, "oor_alias1_ctrl");
      rd(3, 2, 16'd0, "oor_alias3_count");
      rd(7, 2, 16'd0, "oor_rd7_count");

      // 8-bit timebase wrap from 254
      en2 = 1'b1;
      step();
      push(0, K_TIME2, 0, 16'd255, "wrap_255");
      n_vec++;
      if (time2 !== 8'd255) begin
         n_bad++;
         $display("FAIL wrap_255_direct: got 0x%0h", time2);
      end
      step();
      push(0, K_TIME2, 0, 16'd0, "wrap_0");
      step();
      push(0, K_TIME2, 0, 16'd1, "wrap_1");
      en2 = 1'b0;

      step(3);
      while (sb.size() > 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s: never compared, expected 0x%0h", sb[0].name, sb[0].exp);
         sb.delete(0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
